// File: rtl/pnc_spike_if.sv
// Inbound packet handshake and neuron-memory command port of the spike dispatcher.
// master: packet source / memory side; slave: dispatcher side.
interface pnc_spike_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned NADDR_W = 7
);
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_addr;
    logic                mem_valid;
    logic                mem_ready;
    logic [1:0]          mem_cmd;
    logic [NADDR_W-1:0]  mem_addr;
    logic [ADDR_W-2:0]   mem_data;

    modport master (
        output in_valid, in_addr, mem_ready,
        input  in_ready, mem_valid, mem_cmd, mem_addr, mem_data
    );

    modport slave (
        input  in_valid, in_addr, mem_ready,
        output in_ready, mem_valid, mem_cmd, mem_addr, mem_data
    );
endinterface

// File: rtl/pnc_spike_dispatcher.sv
// Decodes core packets into neuron-memory commands, splits dual-address spikes,
// and closes timesteps with a per-timestep spike count.
module pnc_spike_dispatcher #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned NADDR_W = 7,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pnc_spike_if.slave        bus,
    input  logic              ts_end,
    output logic              ts_done,
    output logic [CNT_W-1:0]  ts_spikes,
    output logic [CNT_W-1:0]  null_cnt
);
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LOCAL = 2'b01;
    localparam logic [1:0] CMD_RICH  = 2'b10;
    localparam logic [1:0] CMD_PARAM = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

    state_t              state;
    logic                ts_pending;
    logic                second_pending;
    logic [NADDR_W-1:0]  addr2_q;
    logic [CNT_W-1:0]    spike_cnt;
    logic [CNT_W-1:0]    spike_cnt_next;

    logic                accept;
    logic                is_param;
    logic                is_rich;
    logic [NADDR_W-1:0]  addr1;
    logic [NADDR_W-1:0]  addr2;
    logic                spike_hs;

    assign bus.in_ready = (state == IDLE) && !ts_pending && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_param     = bus.in_addr[ADDR_W-1];
    assign is_rich      = bus.in_addr[ADDR_W-2];
    assign addr1        = bus.in_addr[NADDR_W-1:0];
    assign addr2        = bus.in_addr[2*NADDR_W-1:NADDR_W];

    // Spike handshakes counted this cycle, saturating at all-ones.
    always_comb begin
        spike_hs       = bus.mem_valid && bus.mem_ready &&
                         (bus.mem_cmd == CMD_LOCAL || bus.mem_cmd == CMD_RICH);
        spike_cnt_next = spike_cnt;
        if (spike_hs && spike_cnt != '1)
            spike_cnt_next = spike_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ts_pending     <= 1'b0;
            second_pending <= 1'b0;
            addr2_q        <= '0;
            spike_cnt      <= '0;
            bus.mem_valid  <= 1'b0;
            bus.mem_cmd    <= CMD_NONE;
            bus.mem_addr   <= '0;
            bus.mem_data   <= '0;
            ts_done        <= 1'b0;
            ts_spikes      <= '0;
            null_cnt       <= '0;
        end else begin
            ts_done   <= 1'b0;
            spike_cnt <= spike_cnt_next;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_param) begin
                            bus.mem_valid <= 1'b1;
                            bus.mem_cmd   <= CMD_PARAM;
                            bus.mem_addr  <= '0;
                            bus.mem_data  <= bus.in_addr[ADDR_W-2:0];
                            state         <= ISSUE1;
                        end else if (is_rich) begin
                            bus.mem_valid <= 1'b1;
                            bus.mem_cmd   <= CMD_RICH;
                            bus.mem_addr  <= addr1;
                            bus.mem_data  <= '0;
                            state         <= ISSUE1;
                        end else if (addr1 != '0 || addr2 != '0) begin
                            // Empty first slot collapses a dual packet to one access.
                            bus.mem_valid  <= 1'b1;
                            bus.mem_cmd    <= CMD_LOCAL;
                            bus.mem_addr   <= (addr1 != '0) ? addr1 : addr2;
                            bus.mem_data   <= '0;
                            addr2_q        <= addr2;
                            second_pending <= (addr1 != '0) && (addr2 != '0);
                            state          <= ISSUE1;
                        end else if (null_cnt != '1) begin
                            null_cnt <= null_cnt + CNT_W'(1);
                        end
                    end
                end
                ISSUE1: begin
                    if (bus.mem_ready) begin
                        if (second_pending) begin
                            bus.mem_addr   <= addr2_q;
                            second_pending <= 1'b0;
                            state          <= ISSUE2;
                        end else begin
                            bus.mem_valid <= 1'b0;
                            bus.mem_cmd   <= CMD_NONE;
                            bus.mem_addr  <= '0;
                            bus.mem_data  <= '0;
                            state         <= IDLE;
                        end
                    end
                end
                ISSUE2: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_cmd   <= CMD_NONE;
                        bus.mem_addr  <= '0;
                        bus.mem_data  <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Boundary closes once idle; a repeated ts_end while pending is absorbed.
            if (ts_pending && state == IDLE) begin
                ts_done    <= 1'b1;
                ts_spikes  <= spike_cnt_next;
                spike_cnt  <= '0;
                ts_pending <= 1'b0;
            end else if (ts_end) begin
                ts_pending <= 1'b1;
            end
        end
    end
endmodule
